// File: rtl/ts_sensor_conditioner.sv
// Conditions the raw country-road loop into a debounced, held 'sensor' request with vehicle count and stuck-loop fault.
// Latency: sensor rises DEBOUNCE_CYC+2 edges after raw goes high and falls HOLD_CYC+2 edges after it drops; no backpressure.
module ts_sensor_conditioner #(
   parameter int DEBOUNCE_CYC = 4,
   parameter int HOLD_CYC     = 8,
   parameter int STUCK_CYC    = 64,
   parameter int CNT_W        = 8
) (
   input  logic             i_clk,
   input  logic             i_clear_n,
   input  logic             i_raw_sensor,
   input  logic             i_ctry_green,
   output logic             o_sensor,
   output logic [CNT_W-1:0] o_veh_count,
   output logic             o_fault
);

   localparam int MAX_A  = (DEBOUNCE_CYC > HOLD_CYC) ? DEBOUNCE_CYC : HOLD_CYC;
   localparam int MAX_C  = (MAX_A > STUCK_CYC) ? MAX_A : STUCK_CYC;
   localparam int CW     = $clog2(MAX_C + 1);

   // The qualifying and hold windows each include the sample that caused entry,
   // so those states stop one count earlier than the FAULT release window.
   localparam logic [CW-1:0] QUAL_LAST  = CW'((DEBOUNCE_CYC >= 2) ? DEBOUNCE_CYC - 2 : 0);
   localparam logic [CW-1:0] HOLD_LAST  = CW'((HOLD_CYC >= 2) ? HOLD_CYC - 2 : 0);
   localparam logic [CW-1:0] STUCK_LAST = CW'(STUCK_CYC - 1);
   localparam logic [CW-1:0] CLEAR_LAST = CW'(DEBOUNCE_CYC - 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_QUAL    = 3'd1,
      ST_PRESENT = 3'd2,
      ST_HOLD    = 3'd3,
      ST_FAULT   = 3'd4
   } state_t;

   logic             r_sync1;
   logic             r_sync2;
   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [CNT_W-1:0] r_veh_count;

   state_t           w_state_nxt;
   logic [CW-1:0]    w_cnt_nxt;
   logic             w_new_veh;
   logic             w_s_in;

   assign w_s_in = r_sync2;

   always_ff @(posedge i_clk) begin
      if (!i_clear_n) begin
         r_sync1     <= 1'b0;
         r_sync2     <= 1'b0;
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_veh_count <= '0;
      end else begin
         r_sync1 <= i_raw_sensor;
         r_sync2 <= r_sync1;
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_new_veh && (r_veh_count != {CNT_W{1'b1}})) begin
            r_veh_count <= r_veh_count + 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_new_veh   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_cnt_nxt = '0;
            if (w_s_in) begin
               if (DEBOUNCE_CYC == 1) begin
                  w_state_nxt = ST_PRESENT;
                  w_new_veh   = 1'b1;
               end else begin
                  w_state_nxt = ST_QUAL;
               end
            end
         end
         ST_QUAL: begin
            if (!w_s_in) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt == QUAL_LAST) begin
               w_state_nxt = ST_PRESENT;
               w_cnt_nxt   = '0;
               w_new_veh   = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         ST_PRESENT: begin
            // Departure beats the stuck check when both land on the same cycle.
            if (!w_s_in) begin
               w_state_nxt = (HOLD_CYC == 1) ? ST_IDLE : ST_HOLD;
               w_cnt_nxt   = '0;
            end else if (i_ctry_green) begin
               if (r_cnt == STUCK_LAST) begin
                  w_state_nxt = ST_FAULT;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
         end
         ST_HOLD: begin
            if (w_s_in) begin
               w_state_nxt = ST_PRESENT;
               w_cnt_nxt   = '0;
            end else if (r_cnt == HOLD_LAST) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         ST_FAULT: begin
            if (w_s_in) begin
               w_cnt_nxt = '0;
            end else if (r_cnt == CLEAR_LAST) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign o_sensor    = (r_state == ST_PRESENT) || (r_state == ST_HOLD);
   assign o_fault     = (r_state == ST_FAULT);
   assign o_veh_count = r_veh_count;

endmodule
